// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker for the lfsr generator.
// Fills a history register from the incoming stream and confirms CONFIRM
// correct predictions before declaring lock. While locked, it free-runs
// (flywheels) on its own predictions and flags and counts every mismatching
// bit. It drops lock after LOSS_THRESH consecutive mismatches.
// Optional feature macro: LFSR_CHK_ERRCNT_EN enables the saturating err_cnt
// counter. When the macro is not defined, err_cnt is tied to zero.
module lfsr_checker #(
  parameter int          W           = 32,
  parameter logic [W-1:0] POLY       = 32'h8020_0003,
  parameter int          CONFIRM     = 16,
  parameter int          LOSS_THRESH = 8,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     hist
);

  localparam int FILL_W = $clog2(W + 1);
  localparam int OK_W   = $clog2(CONFIRM + 1);
  localparam int BAD_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(W - 1);
  localparam logic [OK_W-1:0]   OK_LAST   = OK_W'(CONFIRM - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      hist_nxt;
  logic [FILL_W-1:0] fill_cnt, fill_nxt;
  logic [OK_W-1:0]   ok_cnt, ok_nxt;
  logic [BAD_W-1:0]  bad_cnt, bad_nxt;
  logic              err_nxt;
  logic              exp_bit;

  // The next bit the sequence should produce, predicted from the history
  assign exp_bit = ^(hist & POLY);

  // Next-state logic: clr wins over any bit arriving on the same cycle
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill_cnt;
    ok_nxt    = ok_cnt;
    bad_nxt   = bad_cnt;
    err_nxt   = 1'b0;
    if (clr) begin
      state_nxt = ST_HUNT;
      fill_nxt  = '0;
      ok_nxt    = '0;
      bad_nxt   = '0;
    end else if (bit_valid) begin
      case (state)
        ST_HUNT: begin
          hist_nxt = {hist[W-2:0], bit_in};
          if (fill_cnt == FILL_LAST) begin
            fill_nxt = '0;
            // An all-zero history can never be a valid LFSR state, so keep filling
            if (hist_nxt != '0) begin
              state_nxt = ST_CONFIRM;
              ok_nxt    = '0;
            end
          end else begin
            fill_nxt = fill_cnt + FILL_W'(1);
          end
        end
        ST_CONFIRM: begin
          hist_nxt = {hist[W-2:0], bit_in};
          if (bit_in == exp_bit) begin
            if (ok_cnt == OK_LAST) begin
              state_nxt = ST_LOCKED;
              ok_nxt    = '0;
              bad_nxt   = '0;
            end else begin
              ok_nxt = ok_cnt + OK_W'(1);
            end
          end else begin
            state_nxt = ST_HUNT;
            fill_nxt  = '0;
            ok_nxt    = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel on the prediction so a channel error cannot corrupt later predictions
          hist_nxt = {hist[W-2:0], exp_bit};
          if (bit_in != exp_bit) begin
            err_nxt = 1'b1;
            if (bad_cnt == BAD_LAST) begin
              state_nxt = ST_HUNT;
              fill_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_cnt + BAD_W'(1);
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_HUNT;
          fill_nxt  = '0;
          ok_nxt    = '0;
          bad_nxt   = '0;
        end
      endcase
    end
  end

  // State, history, counters and the registered locked/err outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HUNT;
      hist     <= '0;
      fill_cnt <= '0;
      ok_cnt   <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      hist     <= hist_nxt;
      fill_cnt <= fill_nxt;
      ok_cnt   <= ok_nxt;
      bad_cnt  <= bad_nxt;
      locked   <= (state_nxt == ST_LOCKED);
      err      <= err_nxt;
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  // Saturating count of flagged errors, cleared by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (err_nxt && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: randomized, self-checking bench for lfsr_checker.
// A behavioural model of the checker is updated after every clock edge.
// One compare process then checks all outputs on each falling edge.
// Directed checks use hand-derived literals: lock latency, pulse counts and
// saturation.
module tb_lfsr_checker;

  localparam int          W     = 32;
  localparam logic [31:0] POLY  = 32'h8020_0003;
  localparam int          CONF  = 16;
  localparam int          LOSS  = 8;
  localparam int          CNT_W = 16;
`ifdef LFSR_CHK_ERRCNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [W-1:0]     hist;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // model state
  int          m_mode;
  logic [31:0] m_hist;
  int          m_fill, m_ok, m_bad, m_errcnt;
  logic        m_err, m_locked;

  // generator state
  logic [31:0] gen;

  lfsr_checker #(
    .W(W), .POLY(POLY), .CONFIRM(CONF), .LOSS_THRESH(LOSS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .clr(clr), .locked(locked), .err(err), .err_cnt(err_cnt), .hist(hist)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic modelReset();
    m_mode = 0; m_hist = '0; m_fill = 0; m_ok = 0; m_bad = 0;
    m_errcnt = 0; m_err = 1'b0; m_locked = 1'b0;
  endtask

  // Modes: 0 = hunting, 1 = confirming, 2 = locked
  task automatic modelStep(input logic v, input logic b, input logic c);
    logic p;
    if (c) begin
      m_errcnt = 0; m_err = 1'b0; m_mode = 0; m_fill = 0; m_ok = 0; m_bad = 0;
      m_locked = 1'b0;
      return;
    end
    m_err = 1'b0;
    if (!v) return;
    p = (($countones(m_hist & POLY) % 2) == 1);
    if (m_mode == 0) begin
      m_hist = (m_hist << 1) | 32'(b);
      m_fill++;
      if (m_fill == W) begin
        m_fill = 0;
        if (m_hist != 0) begin m_mode = 1; m_ok = 0; end
      end
    end else if (m_mode == 1) begin
      m_hist = (m_hist << 1) | 32'(b);
      if (b == p) begin
        m_ok++;
        if (m_ok == CONF) begin m_mode = 2; m_bad = 0; end
      end else begin
        m_mode = 0; m_fill = 0;
      end
    end else begin
      m_hist = (m_hist << 1) | 32'(p);
      if (b != p) begin
        m_err = 1'b1;
        if (m_errcnt < (1 << CNT_W) - 1) m_errcnt++;
        m_bad++;
        if (m_bad == LOSS) begin m_mode = 0; m_fill = 0; end
      end else begin
        m_bad = 0;
      end
    end
    m_locked = (m_mode == 2);
  endtask

  task automatic genBit(output logic b);
    b = ($countones(gen & POLY) % 2) == 1;
    gen = {gen[30:0], b};
  endtask

  // Drive one cycle of inputs; return on the following falling edge
  task automatic applyStimulus(input logic v, input logic b, input logic c);
    bit_valid = v; bit_in = b; clr = c;
    @(posedge clk);
    #1;
    modelStep(v, b, c);
    @(negedge clk);
  endtask

  task automatic applyReset();
    bit_valid = 1'b0; bit_in = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_locked", longint'(locked), 0);
    checkOutput("rst_err", longint'(err), 0);
    checkOutput("rst_err_cnt", longint'(err_cnt), 0);
    checkOutput("rst_hist", longint'(hist), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Feed clean bits until the DUT reports lock; count valid bits used
  task automatic waitLock(input bit gaps, output int nbits);
    logic b;
    nbits = 0;
    for (int i = 0; i < 400 && !locked; i++) begin
      if (!gaps || (i % 2 == 0)) begin
        genBit(b);
        nbits++;
        applyStimulus(1'b1, b, 1'b0);
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
  endtask

  task automatic sendBits(input int n, input bit invert);
    logic b;
    for (int i = 0; i < n; i++) begin
      genBit(b);
      applyStimulus(1'b1, b ^ invert, 1'b0);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_locked", longint'(locked), longint'(m_locked));
      checkOutput("cyc_err", longint'(err), longint'(m_err));
      checkOutput("cyc_err_cnt", longint'(err_cnt), longint'(CNT_ON * m_errcnt));
      checkOutput("cyc_hist", longint'(hist), longint'(m_hist));
    end
  end

  initial begin
    int   n;
    int   pulses;
    int   forced;
    logic b;

    applyReset();

    // The generator's first two bits from this seed are 0 then 1
    gen = 32'h8020_0003;
    genBit(b);
    checkOutput("gen_bit0", longint'(b), 0);
    genBit(b);
    checkOutput("gen_bit1", longint'(b), 1);
    gen = 32'h8020_0003;

    // clean acquisition
    waitLock(1'b0, n);
    checkOutput("lock_bits", n, 48);
    sendBits(1000, 1'b0);
    checkOutput("clean_err_cnt", longint'(err_cnt), 0);
    checkOutput("clean_locked", longint'(locked), 1);

    // single error on the 100th bit
    pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      genBit(b);
      applyStimulus(1'b1, b ^ (i == 100), 1'b0);
      pulses += int'(err);
    end
    checkOutput("single_pulses", pulses, 1);
    checkOutput("single_err_cnt", longint'(err_cnt), CNT_ON * 1);
    checkOutput("single_locked", longint'(locked), 1);

    // loss after 8 consecutive errors, then relock
    genBit(b);
    applyStimulus(1'b1, b, 1'b1);
    waitLock(1'b0, n);
    checkOutput("clr_relock_bits", n, 48);
    sendBits(7, 1'b1);
    checkOutput("loss_locked_7", longint'(locked), 1);
    sendBits(1, 1'b1);
    checkOutput("loss_locked_8", longint'(locked), 0);
    checkOutput("loss_err_cnt", longint'(err_cnt), CNT_ON * 8);
    waitLock(1'b0, n);
    checkOutput("loss_relock_bits", n, 48);

    // clr while locked with five errors counted
    genBit(b);
    applyStimulus(1'b1, b, 1'b1);
    waitLock(1'b0, n);
    for (int i = 0; i < 5; i++) begin
      sendBits(1, 1'b1);
      sendBits(int'($urandom_range(1, 6)), 1'b0);
    end
    checkOutput("pre_clr_err_cnt", longint'(err_cnt), CNT_ON * 5);
    genBit(b);
    applyStimulus(1'b1, b, 1'b1);
    checkOutput("clr_err_cnt", longint'(err_cnt), 0);
    checkOutput("clr_locked", longint'(locked), 0);
    waitLock(1'b0, n);
    checkOutput("clr_relock2_bits", n, 48);

    // reset in the middle of confirmation
    genBit(b);
    applyStimulus(1'b1, b, 1'b1);
    sendBits(40, 1'b0);
    applyReset();
    waitLock(1'b0, n);
    checkOutput("rst_relock_bits", n, 48);

    // gapped stream
    applyReset();
    waitLock(1'b1, n);
    checkOutput("gap_lock_bits", n, 48);

    // all-zero stream never locks
    applyReset();
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      pulses += int'(locked);
    end
    checkOutput("zero_lock_cycles", pulses, 0);

    // randomized soak: gaps, sparse errors, occasional clr
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        genBit(b);
        applyStimulus(1'b1, b ^ ($urandom_range(0, 63) == 0),
                      1'($urandom_range(0, 499) == 0));
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // saturation: seven errors then one good bit keeps lock while counting
    applyReset();
    waitLock(1'b0, n);
    forced = 0;
    while (forced < 65536) begin
      sendBits(7, 1'b1);
      sendBits(1, 1'b0);
      forced += 7;
    end
    checkOutput("sat_err_cnt", longint'(err_cnt), CNT_ON * 16'hFFFF);
    checkOutput("sat_locked", longint'(locked), 1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
